// File: rtl/cmp_event_monitor.sv
// Event monitor on the GT/EQ/LT verdict stream: a consecutive-sample filter with hysteresis
// drives a registered alarm level, a one-cycle rise pulse and a saturating rise counter.
module cmp_event_monitor #(
    parameter int CONFIRM = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    input  logic             clear,
    output logic             alarm,
    output logic             event_pulse,
    output logic [CNT_W-1:0] event_count,
    output logic             err,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND_HI = 2'd1,
        HIGH    = 2'd2,
        PEND_LO = 2'd3
    } state_t;

    localparam logic [3:0] CONF = 4'(CONFIRM);

    state_t     st;
    logic [3:0] run_cnt;
    logic [1:0] n_hot;
    logic       smp_legal;
    logic       smp_illegal;
    logic       run_done;
    logic       cnt_full;

    always_comb begin
        n_hot       = {1'b0, gt} + {1'b0, eq} + {1'b0, lt};
        smp_legal   = in_valid && (n_hot == 2'd1);
        smp_illegal = in_valid && (n_hot != 2'd1);
        // run_cnt is 0 in IDLE and HIGH, so this also covers the CONFIRM=1 shortcut
        run_done    = (run_cnt + 4'd1) == CONF;
        cnt_full    = &event_count;
    end

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            run_cnt     <= 4'd0;
            alarm       <= 1'b0;
            event_pulse <= 1'b0;
            event_count <= '0;
            err         <= 1'b0;
        end else if (clear) begin
            st          <= IDLE;
            run_cnt     <= 4'd0;
            alarm       <= 1'b0;
            event_pulse <= 1'b0;
            event_count <= '0;
            err         <= 1'b0;
        end else begin
            event_pulse <= 1'b0;
            if (smp_illegal) begin
                err <= 1'b1;
            end else if (smp_legal) begin
                unique case (st)
                    IDLE, PEND_HI: begin
                        if (gt) begin
                            if (run_done) begin
                                st          <= HIGH;
                                run_cnt     <= 4'd0;
                                alarm       <= 1'b1;
                                event_pulse <= 1'b1;
                                if (!cnt_full) event_count <= event_count + CNT_W'(1);
                            end else begin
                                st      <= PEND_HI;
                                run_cnt <= run_cnt + 4'd1;
                            end
                        end else begin
                            st      <= IDLE;
                            run_cnt <= 4'd0;
                        end
                    end
                    HIGH, PEND_LO: begin
                        // Leaving the alarm needs a full run of lt; eq or gt resets the run
                        if (lt) begin
                            if (run_done) begin
                                st      <= IDLE;
                                run_cnt <= 4'd0;
                                alarm   <= 1'b0;
                            end else begin
                                st      <= PEND_LO;
                                run_cnt <= run_cnt + 4'd1;
                            end
                        end else begin
                            st      <= HIGH;
                            run_cnt <= 4'd0;
                        end
                    end
                    default: begin
                        st      <= IDLE;
                        run_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmp_event_monitor.sv
// Scoreboard bench for cmp_event_monitor: two instances (CONFIRM=4/CNT_W=2 and CONFIRM=1/CNT_W=8)
// share one stimulus stream; a level/run reference model predicts every post-edge output.
module tb_cmp_event_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, gt = 1'b0, eq = 1'b0, lt = 1'b0, clear = 1'b0;

    always #5 clk = ~clk;

    logic       a_alarm, a_pulse, a_err;
    logic [1:0] a_cnt, a_state;
    logic       b_alarm, b_pulse, b_err;
    logic [7:0] b_cnt;
    logic [1:0] b_state;

    cmp_event_monitor #(.CONFIRM(4), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gt(gt), .eq(eq), .lt(lt),
        .clear(clear), .alarm(a_alarm), .event_pulse(a_pulse), .event_count(a_cnt),
        .err(a_err), .state(a_state)
    );

    cmp_event_monitor #(.CONFIRM(1), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gt(gt), .eq(eq), .lt(lt),
        .clear(clear), .alarm(b_alarm), .event_pulse(b_pulse), .event_count(b_cnt),
        .err(b_err), .state(b_state)
    );

    typedef struct packed {
        logic       alarm;
        logic       pulse;
        logic [7:0] cnt;
        logic       err;
        logic [1:0] st;
    } obs_t;

    obs_t q_a[$];
    obs_t q_b[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: the qualified level plus the length of the current run opposing it.
    int m_above[2];
    int m_run[2];
    int m_cnt[2];
    int m_err[2];
    int m_pulse[2];
    int m_conf[2] = '{4, 1};
    int m_max[2]  = '{3, 255};

    localparam int IDL = 0, GT = 1, EQ = 2, LT = 3, ILL = 4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_above[k] = 0; m_run[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_pulse[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic v, g, e, l, c);
        int opposes;
        m_pulse[k] = 0;
        if (c) begin
            m_above[k] = 0; m_run[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
            return;
        end
        if (!v) return;
        if (int'(g) + int'(e) + int'(l) != 1) begin
            m_err[k] = 1;
            return;
        end
        opposes = m_above[k] != 0 ? int'(l) : int'(g);
        if (opposes != 0) begin
            m_run[k]++;
            if (m_run[k] == m_conf[k]) begin
                m_above[k] = m_above[k] != 0 ? 0 : 1;
                m_run[k] = 0;
                if (m_above[k] != 0) begin
                    m_pulse[k] = 1;
                    if (m_cnt[k] < m_max[k]) m_cnt[k]++;
                end
            end
        end else begin
            m_run[k] = 0;
        end
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t o;
        o.alarm = m_above[k] != 0;
        o.pulse = m_pulse[k] != 0;
        o.cnt   = 8'(m_cnt[k]);
        o.err   = m_err[k] != 0;
        if (m_above[k] != 0) o.st = (m_run[k] > 0) ? 2'd3 : 2'd2;
        else                 o.st = (m_run[k] > 0) ? 2'd1 : 2'd0;
        return o;
    endfunction

    task automatic drive(input logic v, g, e, l, c);
        @(negedge clk);
        in_valid = v; gt = g; eq = e; lt = l; clear = c;
        model_step(0, v, g, e, l, c);
        model_step(1, v, g, e, l, c);
        q_a.push_back(model_obs(0));
        q_b.push_back(model_obs(1));
        @(posedge clk);
    endtask

    task automatic smp(input int kind);
        case (kind)
            GT:      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            EQ:      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            LT:      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            ILL:     drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        endcase
    endtask

    task automatic rep(input int kind, input int n);
        for (int i = 0; i < n; i++) smp(kind);
    endtask

    task automatic rst_check();
        chk("rst_a_alarm", a_alarm, 0); chk("rst_a_pulse", a_pulse, 0);
        chk("rst_a_cnt", a_cnt, 0);     chk("rst_a_err", a_err, 0);
        chk("rst_a_state", a_state, 0);
        chk("rst_b_alarm", b_alarm, 0); chk("rst_b_pulse", b_pulse, 0);
        chk("rst_b_cnt", b_cnt, 0);     chk("rst_b_err", b_err, 0);
        chk("rst_b_state", b_state, 0);
    endtask

    // Monitor: outputs are presented every cycle, compared one step after each sampling edge
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("a_alarm", a_alarm, e.alarm);
                chk("a_pulse", a_pulse, e.pulse);
                chk("a_cnt", a_cnt, e.cnt[1:0]);
                chk("a_err", a_err, e.err);
                chk("a_state", a_state, e.st);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("b_alarm", b_alarm, e.alarm);
                chk("b_pulse", b_pulse, e.pulse);
                chk("b_cnt", b_cnt, e.cnt);
                chk("b_err", b_err, e.err);
                chk("b_state", b_state, e.st);
            end
        end
    end

    initial begin
        logic [2:0] ill_tab [5];
        logic [2:0] ill;
        int mode;
        int r;
        ill_tab = '{3'b000, 3'b110, 3'b101, 3'b011, 3'b111};
        model_reset();
        #12;
        rst_check();
        @(negedge clk);
        rst_n = 1'b1;

        // qualify and rise, then a broken run from IDLE
        rep(GT, 4); rep(IDL, 2);
        rep(LT, 4);
        rep(GT, 3); smp(EQ); rep(GT, 3); smp(EQ);
        // hysteresis and release
        rep(GT, 4); rep(EQ, 10); smp(LT); smp(LT); smp(GT); rep(LT, 4);
        // illegal mid-run, gaps do not break the run, then clear beats a legal gt
        rep(GT, 2); smp(ILL); smp(IDL); rep(GT, 2); smp(IDL);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        smp(IDL);
        // single-confirm instance: gt, lt, gt gives pulses two cycles apart
        smp(GT); smp(LT); smp(GT); smp(LT);
        // saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            rep(GT, 4); smp(IDL); rep(LT, 4);
        end
        // async reset between edges in the middle of a pending rise
        rep(GT, 2);
        #2 rst_n = 1'b0;
        #1 rst_check();
        model_reset();
        #1 rst_n = 1'b1;
        rep(GT, 3); smp(EQ); smp(IDL);

        // randomized segments biased toward gt runs, lt runs or uniform verdicts
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 16 == 0) mode = int'($urandom_range(0, 2));
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            end else if (r < 6) begin
                ill = ill_tab[$urandom_range(0, 4)];
                drive(1'b1, ill[2], ill[1], ill[0], 1'b0);
            end else if (r < 16) begin
                smp(IDL);
            end else begin
                r = int'($urandom_range(0, 99));
                case (mode)
                    0:       smp(r < 80 ? GT : (r < 90 ? EQ : LT));
                    1:       smp(r < 80 ? LT : (r < 90 ? EQ : GT));
                    default: smp(r < 34 ? GT : (r < 67 ? EQ : LT));
                endcase
            end
        end
        smp(IDL);
        @(negedge clk);
        chk("queue_drained", q_a.size() + q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
